i2c_slave: RTL and testbench



---
 rtl/i2c_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C slave byte engine: synchronizes sclk/sda, detects START/STOP, ACKs its address, receives and transmits bytes.
// Optional 3-sample majority glitch filter on both lines when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave #(
    parameter logic [6:0] I2C_SLAVE_ADDRESS = 7'h2D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic [3:0] state
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] RX       = 4'd3;
    localparam logic [3:0] RX_ACK   = 4'd4;
    localparam logic [3:0] TX       = 4'd5;
    localparam logic [3:0] TX_ACK   = 4'd6;
    localparam logic [3:0] IGNORE   = 4'd7;

    logic [1:0] sclk_sync;
    logic [1:0] sda_sync;
    logic       sclk_f;
    logic       sda_f;
    logic       sclk_prev;
    logic       sda_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '1;
            sda_sync  <= '1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            sda_sync  <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] sclk_win;
    logic [2:0] sda_win;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Registered majority output gives 5 clk total from pin to decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_win <= '1;
            sda_win  <= '1;
            sclk_f   <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            sclk_win <= {sclk_win[1:0], sclk_sync[1]};
            sda_win  <= {sda_win[1:0], sda_sync[1]};
            sclk_f   <= maj3(sclk_win);
            sda_f    <= maj3(sda_win);
        end
    end
`else
    assign sclk_f = sclk_sync[1];
    assign sda_f  = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev <= 1'b1;
            sda_prev  <= 1'b1;
        end else begin
            sclk_prev <= sclk_f;
            sda_prev  <= sda_f;
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic start_det;
    logic stop_det;

    assign sclk_rise = sclk_f & ~sclk_prev;
    assign sclk_fall = ~sclk_f & sclk_prev;
    assign start_det = sclk_f & sclk_prev & sda_prev & ~sda_f;
    assign stop_det  = sclk_f & sclk_prev & ~sda_prev & sda_f;

    logic [3:0] state_r;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] tx_shift;
    logic [7:0] shift_next;
    logic       byte_done;
    logic       rw;
    logic       nack;

    assign shift_next = {shift[6:0], sda_f};
    assign state      = state_r;

    // byte_done marks "8th rising edge seen, act on the following falling edge".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            sda_out   <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_shift  <= '0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            nack      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                state_r   <= ADDR;
                bit_cnt   <= '0;
                busy      <= 1'b1;
                byte_done <= 1'b0;
            end else if (stop_det) begin
                state_r   <= IDLE;
                busy      <= 1'b0;
                sda_out   <= 1'b1;
                byte_done <= 1'b0;
            end else begin
                case (state_r)
                    ADDR: begin
                        if (sclk_rise && !byte_done) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift[6:0] == I2C_SLAVE_ADDRESS) begin
                                    byte_done <= 1'b1;
                                    rw        <= sda_f;
                                end else begin
                                    state_r <= IGNORE;
                                end
                            end
                        end else if (sclk_fall && byte_done) begin
                            sda_out   <= 1'b0;
                            byte_done <= 1'b0;
                            state_r   <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (sclk_fall) begin
                            if (rw) begin
                                tx_shift <= tx_data;
                                sda_out  <= tx_data[7];
                                tx_req   <= 1'b1;
                                state_r  <= TX;
                            end else begin
                                sda_out <= 1'b1;
                                state_r <= RX;
                            end
                        end
                    end
                    RX: begin
                        if (sclk_rise && !byte_done) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= shift_next;
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (sclk_fall && byte_done) begin
                            sda_out   <= 1'b0;
                            byte_done <= 1'b0;
                            state_r   <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (sclk_fall) begin
                            sda_out <= 1'b1;
                            state_r <= RX;
                        end
                    end
                    TX: begin
                        if (sclk_rise && !byte_done) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                byte_done <= 1'b1;
                        end else if (sclk_fall) begin
                            if (byte_done) begin
                                sda_out   <= 1'b1;
                                byte_done <= 1'b0;
                                state_r   <= TX_ACK;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sda_out  <= tx_shift[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (sclk_rise && !byte_done) begin
                            nack      <= sda_f;
                            byte_done <= 1'b1;
                        end else if (sclk_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (!nack) begin
                                tx_shift <= tx_data;
                                sda_out  <= tx_data[7];
                                tx_req   <= 1'b1;
                                state_r  <= TX;
                            end else begin
                                sda_out <= 1'b1;
                                state_r <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: write, read, address miss, repeated START, mid-transfer reset, optional glitch filter.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sda_m;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic [3:0] state;

    int unsigned rxv_cnt = 0;
    int unsigned txr_cnt = 0;
    int unsigned passed  = 0;
    int unsigned fails   = 0;
    int unsigned total   = 0;

    assign sda_in = sda_m & sda_out;

    i2c_slave #(.I2C_SLAVE_ADDRESS(7'h2D)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda_in   (sda_in),
        .sda_out  (sda_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (tx_req)   txr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        sda_m = b;
        w(4);
        sclk = 1'b1;
        w(4);
        seen = sda_in;
        w(4);
        sclk = 1'b0;
        w(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, s);
            b = {b[6:0], s};
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        w(4);
        sclk = 1'b1;
        w(8);
        sda_m = 1'b0;
        w(8);
        sclk = 1'b0;
        w(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        w(4);
        sclk = 1'b1;
        w(8);
        sda_m = 1'b1;
        w(8);
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        int unsigned r0;
        int unsigned t0;

        rst     = 1'b0;
        sclk    = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'hA5;
        w(3);
        check("rst_state",    32'(state),    0);
        check("rst_sda_out",  32'(sda_out),  1);
        check("rst_busy",     32'(busy),     0);
        check("rst_rx_data",  32'(rx_data),  0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_tx_req",   32'(tx_req),   0);
        rst = 1'b1;
        w(4);

        // Write 0x5A then 0xC3
        r0 = rxv_cnt;
        i2c_start();
        check("wr_busy_start", 32'(busy),  1);
        check("wr_state_addr", 32'(state), 1);
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        check("wr_addr_ack", 32'(a), 0);
        send_byte(8'hC3);
        i2c_bit(1'b1, a);
        check("wr_data_ack", 32'(a), 0);
        i2c_stop();
        check("wr_busy_stop", 32'(busy),    0);
        check("wr_state_idle", 32'(state),  0);
        check("wr_rx_data",   32'(rx_data), 'hC3);
        check("wr_rxv_count", rxv_cnt - r0, 1);

        // Read 0xA5 twice: ACK then NACK
        t0 = txr_cnt;
        i2c_start();
        send_byte(8'h5B);
        i2c_bit(1'b1, a);
        check("rd_addr_ack", 32'(a), 0);
        read_byte(b);
        check("rd_byte1", 32'(b), 'hA5);
        i2c_bit(1'b0, a);
        read_byte(b);
        check("rd_byte2", 32'(b), 'hA5);
        i2c_bit(1'b1, a);
        w(8);
        check("rd_state_ignore", 32'(state), 7);
        check("rd_txreq_count", txr_cnt - t0, 2);
        i2c_stop();
        check("rd_state_idle", 32'(state), 0);

        // Foreign address 0x40
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h40);
        i2c_bit(1'b1, a);
        check("ign_no_ack", 32'(a), 1);
        check("ign_state", 32'(state), 7);
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        check("ign_no_ack2", 32'(a), 1);
        send_byte(8'hC3);
        i2c_bit(1'b1, a);
        i2c_stop();
        check("ign_rxv_count", rxv_cnt - r0, 0);

        // Repeated START after 4 data bits
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        check("rs_addr_ack", 32'(a), 0);
        i2c_bit(1'b1, a);
        i2c_bit(1'b0, a);
        i2c_bit(1'b1, a);
        i2c_bit(1'b0, a);
        i2c_start();
        check("rs_state_addr", 32'(state), 1);
        check("rs_bit_cnt", 32'(dut.bit_cnt), 0);
        check("rs_no_rxv", rxv_cnt - r0, 0);
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        check("rs_addr_ack2", 32'(a), 0);
        send_byte(8'h3C);
        i2c_bit(1'b1, a);
        i2c_stop();
        check("rs_rx_data", 32'(rx_data), 'h3C);
        check("rs_rxv_count", rxv_cnt - r0, 1);

        // Reset during 5th data bit
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        i2c_bit(1'b0, a);
        i2c_bit(1'b0, a);
        i2c_bit(1'b0, a);
        i2c_bit(1'b1, a);
        sda_m = 1'b0;
        w(4);
        sclk = 1'b1;
        w(2);
        rst = 1'b0;
        #1;
        check("mr_sda_out", 32'(sda_out), 1);
        check("mr_state",   32'(state),   0);
        check("mr_rx_data", 32'(rx_data), 0);
        check("mr_busy",    32'(busy),    0);
        w(2);
        sclk = 1'b0;
        w(4);
        sda_m = 1'b1;
        w(4);
        rst = 1'b1;
        w(8);
        check("mr_state_after", 32'(state), 0);
        check("mr_no_rxv", rxv_cnt - r0, 0);
        i2c_start();
        send_byte(8'h5A);
        i2c_bit(1'b1, a);
        check("mr_addr_ack", 32'(a), 0);
        send_byte(8'h11);
        i2c_bit(1'b1, a);
        i2c_stop();
        check("mr_rx_data_clean", 32'(rx_data), 'h11);
        check("mr_rxv_count", rxv_cnt - r0, 1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-clk low glitch on sda with sclk high
        @(posedge clk);
        #1;
        sda_m = 1'b0;
        @(posedge clk);
        #1;
        sda_m = 1'b1;
        w(12);
        check("gl_state", 32'(state), 0);
        check("gl_busy",  32'(busy),  0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
